// File: rtl/call_register.sv
// rtl/call_register.sv - elevator call register: synchronised button edges latched as pending calls,
// cleared by direction-aware service at the current floor, with above/below/here/count summaries.
module call_register #(
  parameter int FLOORS      = 7,
  parameter int FLOOR_W     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  hall_up_btn,
  input  logic [FLOORS-1:0]  hall_dn_btn,
  input  logic [FLOORS-1:0]  car_btn,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic [1:0]         current_direction,
  input  logic               door_open,
  input  logic               cancel_car,
  output logic [FLOORS-1:0]  hall_up_lat,
  output logic [FLOORS-1:0]  hall_dn_lat,
  output logic [FLOORS-1:0]  car_lat,
  output logic               any_above,
  output logic               any_below,
  output logic               any_here,
  output logic [CNT_W-1:0]   pending_count
);

  localparam int RW = 3 * FLOORS;

  // Hall up at the top floor and hall down at the bottom floor do not exist.
  localparam logic [FLOORS-1:0] UP_KEEP = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_KEEP = {{(FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FLOORS-1:0] BOTTOM  = {{(FLOORS-1){1'b0}}, 1'b1};
  localparam logic [FLOORS-1:0] TOP     = {1'b1, {(FLOORS-1){1'b0}}};

  logic [RW-1:0]     sync_q [SYNC_STAGES];
  logic [RW-1:0]     hist_q;
  logic [RW-1:0]     press;
  logic [FLOORS-1:0] press_up, press_dn, press_car;

  logic [FLOORS-1:0] here_mask, above_mask, below_mask;
  logic              in_range;
  logic              dir_up, dir_dn;
  logic [FLOORS-1:0] serve, clr_up, clr_dn, clr_car;
  logic [FLOORS-1:0] up_next, dn_next, car_next;
  logic [FLOORS-1:0] all_lat;
  logic [CNT_W-1:0]  count;

  assign press     = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign press_up  = press[FLOORS-1:0];
  assign press_dn  = press[2*FLOORS-1:FLOORS];
  assign press_car = press[3*FLOORS-1:2*FLOORS];

  always_comb begin
    here_mask  = '0;
    above_mask = '0;
    below_mask = '0;
    in_range   = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      here_mask[i] = (current_floor == FLOOR_W'(i));
    end
    in_range = |here_mask;
    // Out of range the car is treated as above every floor.
    for (int i = 0; i < FLOORS; i++) begin
      above_mask[i] = in_range && (FLOOR_W'(i) > current_floor);
      below_mask[i] = !in_range || (FLOOR_W'(i) < current_floor);
    end
  end

  assign dir_up = (current_direction == 2'b01);
  assign dir_dn = (current_direction == 2'b10);

  always_comb begin
    serve   = door_open ? here_mask : '0;
    clr_car = serve | {FLOORS{cancel_car}};
    clr_up  = dir_dn ? (serve & BOTTOM) : serve;
    clr_dn  = dir_up ? (serve & TOP) : serve;
    up_next  = (hall_up_lat | press_up) & ~clr_up & UP_KEEP;
    dn_next  = (hall_dn_lat | press_dn) & ~clr_dn & DN_KEEP;
    car_next = (car_lat | press_car) & ~clr_car;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q      <= '0;
      hall_up_lat <= '0;
      hall_dn_lat <= '0;
      car_lat     <= '0;
    end else begin
      sync_q[0] <= {car_btn, hall_dn_btn, hall_up_btn};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q      <= sync_q[SYNC_STAGES-1];
      hall_up_lat <= up_next;
      hall_dn_lat <= dn_next;
      car_lat     <= car_next;
    end
  end

  assign all_lat   = hall_up_lat | hall_dn_lat | car_lat;
  assign any_here  = |(all_lat & here_mask);
  assign any_above = |(all_lat & above_mask);
  assign any_below = |(all_lat & below_mask);

  always_comb begin
    count = '0;
    for (int i = 0; i < FLOORS; i++) begin
      count = count + CNT_W'(hall_up_lat[i]) + CNT_W'(hall_dn_lat[i]) + CNT_W'(car_lat[i]);
    end
  end
  assign pending_count = count;

endmodule

// File: tb/tb_call_register.sv
// tb/tb_call_register.sv - table-driven and randomized bench for call_register with a floor-rule model.
module tb_call_register;
  localparam int F = 7;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [F-1:0] hall_up_btn, hall_dn_btn, car_btn;
  logic [2:0]   current_floor;
  logic [1:0]   current_direction;
  logic         door_open, cancel_car;
  logic [F-1:0] hall_up_lat, hall_dn_lat, car_lat;
  logic         any_above, any_below, any_here;
  logic [4:0]   pending_count;

  call_register #(.FLOORS(F), .FLOOR_W(3), .SYNC_STAGES(S), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .hall_up_btn(hall_up_btn), .hall_dn_btn(hall_dn_btn), .car_btn(car_btn),
    .current_floor(current_floor), .current_direction(current_direction),
    .door_open(door_open), .cancel_car(cancel_car),
    .hall_up_lat(hall_up_lat), .hall_dn_lat(hall_dn_lat), .car_lat(car_lat),
    .any_above(any_above), .any_below(any_below), .any_here(any_here),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: pending calls per floor plus the raw samples seen at each edge.
  logic [F-1:0]   m_up, m_dn, m_car;
  logic [3*F-1:0] samples [$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_up = '0; m_dn = '0; m_car = '0;
    samples.delete();
    for (int i = 0; i < S + 2; i++) samples.push_back('0);
  endtask

  task automatic model_edge(input logic [3*F-1:0] raw, input int cf, input int cd,
                            input logic door, input logic cancel);
    logic [3*F-1:0] pr;
    samples.push_front(raw);
    // A press reaches the latch S edges after the edge that first sampled it high.
    pr = samples[S] & ~samples[S+1];
    void'(samples.pop_back());
    for (int f = 0; f < F; f++) begin
      bit served;
      m_up[f]  = m_up[f]  | pr[f];
      m_dn[f]  = m_dn[f]  | pr[F+f];
      m_car[f] = m_car[f] | pr[2*F+f];
      served = door && (cf < F) && (f == cf);
      if (served) begin
        m_car[f] = 1'b0;
        if (cd != 2 || f == 0)     m_up[f] = 1'b0;
        if (cd != 1 || f == F - 1) m_dn[f] = 1'b0;
      end
      if (cancel) m_car[f] = 1'b0;
    end
    m_up[F-1] = 1'b0;
    m_dn[0]   = 1'b0;
  endtask

  task automatic compare_all();
    int cf;
    bit ab, be, he;
    cf = int'(current_floor);
    ab = 0; be = 0; he = 0;
    for (int f = 0; f < F; f++) begin
      if (m_up[f] || m_dn[f] || m_car[f]) begin
        if (cf >= F) be = 1;
        else if (f > cf) ab = 1;
        else if (f < cf) be = 1;
        else he = 1;
      end
    end
    chk("hall_up_lat", int'(hall_up_lat), int'(m_up));
    chk("hall_dn_lat", int'(hall_dn_lat), int'(m_dn));
    chk("car_lat", int'(car_lat), int'(m_car));
    chk("any_above", int'(any_above), int'(ab));
    chk("any_below", int'(any_below), int'(be));
    chk("any_here", int'(any_here), int'(he));
    chk("pending_count", int'(pending_count), $countones(m_up) + $countones(m_dn) + $countones(m_car));
  endtask

  task automatic tick();
    logic [3*F-1:0] raw;
    int cf, cd;
    logic door, cancel, rs;
    raw = {car_btn, hall_dn_btn, hall_up_btn};
    cf = int'(current_floor); cd = int'(current_direction);
    door = door_open; cancel = cancel_car; rs = reset;
    @(posedge clk);
    #1;
    if (!rs) model_reset();
    else model_edge(raw, cf, cd, door, cancel);
    compare_all();
  endtask

  typedef struct {
    logic [F-1:0] up, dn, car;
    logic [2:0]   floor;
    logic [1:0]   dir;
    logic         door, cancel;
    int           ncyc;
    logic [F-1:0] eu, ed, ec;
    int           ecnt;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic [F-1:0] up, dn, car, input logic [2:0] fl, input logic [1:0] dir,
                     input logic door, cancel, input int ncyc,
                     input logic [F-1:0] eu, ed, ec, input int ecnt);
    vec_t v;
    v.up = up; v.dn = dn; v.car = car; v.floor = fl; v.dir = dir;
    v.door = door; v.cancel = cancel; v.ncyc = ncyc;
    v.eu = eu; v.ed = ed; v.ec = ec; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    hall_up_btn = '0; hall_dn_btn = '0; car_btn = '0;
    current_floor = 3'd2; current_direction = 2'b00;
    door_open = 1'b0; cancel_car = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    //   up     dn     car    fl  dir   door cancel n   exp_up exp_dn exp_car cnt
    add(7'h00, 7'h00, 7'h20, 2, 2'b00, 0, 0, 1,  7'h00, 7'h00, 7'h00, 0);
    add(7'h00, 7'h00, 7'h00, 2, 2'b00, 0, 0, 2,  7'h00, 7'h00, 7'h20, 1);
    add(7'h08, 7'h00, 7'h00, 2, 2'b00, 0, 0, 20, 7'h08, 7'h00, 7'h20, 2);
    add(7'h00, 7'h00, 7'h00, 2, 2'b00, 0, 0, 3,  7'h08, 7'h00, 7'h20, 2);
    add(7'h08, 7'h00, 7'h00, 2, 2'b00, 0, 0, 5,  7'h08, 7'h00, 7'h20, 2);
    add(7'h08, 7'h00, 7'h00, 3, 2'b01, 1, 0, 1,  7'h00, 7'h00, 7'h20, 1);
    add(7'h00, 7'h00, 7'h00, 3, 2'b01, 1, 0, 2,  7'h00, 7'h00, 7'h20, 1);
    add(7'h08, 7'h00, 7'h00, 3, 2'b01, 1, 0, 1,  7'h00, 7'h00, 7'h20, 1);
    add(7'h00, 7'h00, 7'h00, 3, 2'b01, 1, 0, 4,  7'h00, 7'h00, 7'h20, 1);
    add(7'h08, 7'h08, 7'h08, 3, 2'b10, 0, 0, 1,  7'h00, 7'h00, 7'h20, 1);
    add(7'h00, 7'h00, 7'h00, 3, 2'b10, 0, 0, 3,  7'h08, 7'h08, 7'h28, 4);
    add(7'h00, 7'h00, 7'h00, 3, 2'b10, 1, 0, 1,  7'h08, 7'h00, 7'h20, 2);
    add(7'h40, 7'h40, 7'h00, 6, 2'b01, 0, 0, 1,  7'h08, 7'h00, 7'h20, 2);
    add(7'h00, 7'h00, 7'h00, 6, 2'b01, 0, 0, 3,  7'h08, 7'h40, 7'h20, 3);
    add(7'h00, 7'h00, 7'h00, 6, 2'b01, 1, 0, 1,  7'h08, 7'h00, 7'h20, 2);
    add(7'h01, 7'h01, 7'h00, 0, 2'b10, 0, 0, 1,  7'h08, 7'h00, 7'h20, 2);
    add(7'h00, 7'h00, 7'h00, 0, 2'b10, 0, 0, 3,  7'h09, 7'h00, 7'h20, 3);
    add(7'h00, 7'h00, 7'h00, 0, 2'b10, 1, 0, 1,  7'h08, 7'h00, 7'h20, 2);
    add(7'h20, 7'h00, 7'h52, 2, 2'b00, 0, 0, 1,  7'h08, 7'h00, 7'h20, 2);
    add(7'h00, 7'h00, 7'h00, 2, 2'b00, 0, 0, 2,  7'h28, 7'h00, 7'h72, 6);
    add(7'h00, 7'h00, 7'h04, 2, 2'b00, 0, 0, 1,  7'h28, 7'h00, 7'h72, 6);
    add(7'h00, 7'h00, 7'h00, 2, 2'b00, 0, 0, 1,  7'h28, 7'h00, 7'h72, 6);
    add(7'h00, 7'h00, 7'h00, 2, 2'b00, 0, 1, 1,  7'h28, 7'h00, 7'h00, 2);
    add(7'h00, 7'h00, 7'h00, 2, 2'b00, 0, 0, 2,  7'h28, 7'h00, 7'h00, 2);

    for (int r = 0; r < tbl.size(); r++) begin
      hall_up_btn = tbl[r].up; hall_dn_btn = tbl[r].dn; car_btn = tbl[r].car;
      current_floor = tbl[r].floor; current_direction = tbl[r].dir;
      door_open = tbl[r].door; cancel_car = tbl[r].cancel;
      repeat (tbl[r].ncyc) tick();
      chk($sformatf("row%0d up", r), int'(hall_up_lat), int'(tbl[r].eu));
      chk($sformatf("row%0d dn", r), int'(hall_dn_lat), int'(tbl[r].ed));
      chk($sformatf("row%0d car", r), int'(car_lat), int'(tbl[r].ec));
      chk($sformatf("row%0d cnt", r), int'(pending_count), tbl[r].ecnt);
    end

    // Asynchronous reset between edges drops calls without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_reset up", int'(hall_up_lat), 0);
    chk("async_reset cnt", int'(pending_count), 0);
    compare_all();

    // Button held across reset release latches once, S+1 edges after release.
    car_btn = 7'h08;
    tick();
    @(negedge clk);
    reset = 1'b1;
    repeat (S) tick();
    chk("held_release early", int'(car_lat), 0);
    tick();
    chk("held_release latch", int'(car_lat), 32'h08);
    car_btn = '0;

    // Out-of-range floor: presses latch, nothing clears.
    current_floor = 3'd7; current_direction = 2'b00; door_open = 1'b1;
    hall_up_btn = 7'h02; hall_dn_btn = 7'h20;
    tick();
    hall_up_btn = '0; hall_dn_btn = '0;
    repeat (3) tick();
    chk("oor up", int'(hall_up_lat), 32'h02);
    chk("oor dn", int'(hall_dn_lat), 32'h20);
    chk("oor car", int'(car_lat), 32'h08);
    chk("oor below", int'(any_below), 1);
    chk("oor above", int'(any_above), 0);
    chk("oor here", int'(any_here), 0);
    door_open = 1'b0;

    // Randomized traffic against the floor-rule model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) hall_up_btn = hall_up_btn ^ F'(1 << $urandom_range(0, F-1));
      if ($urandom_range(0, 3) == 0) hall_dn_btn = hall_dn_btn ^ F'(1 << $urandom_range(0, F-1));
      if ($urandom_range(0, 3) == 0) car_btn = car_btn ^ F'(1 << $urandom_range(0, F-1));
      if ($urandom_range(0, 5) == 0) current_floor = 3'($urandom_range(0, 7));
      current_direction = 2'($urandom_range(0, 3));
      door_open = ($urandom_range(0, 2) == 0);
      cancel_car = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
